// File: rtl/online_sd_to_tc.sv
// Purpose: on-the-fly conversion of an MSD-first borrow-save digit stream into a two's-complement word.
// Latency: out_valid rises on the edge that accepts the final digit of a frame (no extra pipeline stage).
// Backpressure: only a final digit that would overwrite an unread result is stalled; earlier digits flow.
module online_sd_to_tc #(
    parameter int Stage = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_digit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Stage:0]   out_data
);

    localparam int CW = $clog2(Stage) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(Stage - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [Stage:0] q_q, q_d;
    logic [Stage:0] qm_q, qm_d;
    logic [Stage:0] out_data_q, out_data_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           dig_pos;
    logic           dig_neg;
    logic           last_digit;
    logic           xfer;
    logic           fin;
    logic [Stage:0] q_next;
    logic [Stage:0] qm_next;

    // Digit decode, handshake and the Q/QM shift-append candidates for this digit.
    always_comb begin
        dig_pos    = in_digit[1] & ~in_digit[0];
        dig_neg    = in_digit[0] & ~in_digit[1];
        last_digit = (cnt_q == LAST_CNT);
        in_ready   = !((state_q == FULL) && !out_ready && last_digit);
        xfer       = in_valid && in_ready;
        fin        = xfer && last_digit;
        // Zero digit (00 or 11) is the default: Q appends 0, QM appends 1.
        q_next     = {q_q[Stage-1:0], 1'b0};
        qm_next    = {qm_q[Stage-1:0], 1'b1};
        if (dig_pos) begin
            q_next  = {q_q[Stage-1:0], 1'b1};
            qm_next = {q_q[Stage-1:0], 1'b0};
        end else if (dig_neg) begin
            q_next  = {qm_q[Stage-1:0], 1'b1};
            qm_next = {qm_q[Stage-1:0], 1'b0};
        end
    end

    // Datapath next state: accumulate accepted digits, capture and reinitialise on the final one.
    always_comb begin
        q_d        = q_q;
        qm_d       = qm_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        if (xfer) begin
            if (last_digit) begin
                out_data_d = q_next;
                q_d        = '0;
                qm_d       = '1;
                cnt_d      = '0;
            end else begin
                q_d   = q_next;
                qm_d  = qm_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output-side FSM: a new result always wins over the pending one being drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (fin) state_d = FULL;
            FULL: begin
                if (fin)            state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous reset; a partial frame is discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            q_q        <= '0;
            qm_q       <= '1;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            qm_q       <= qm_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_online_sd_to_tc.sv
// Purpose: self-checking bench for online_sd_to_tc (Stage=4 directed vectors, Stage=8 random frames).
// Latency: results expected on the cycle after the final digit's accepting edge.
// Backpressure: exercised by holding out_ready low and by random out_ready gaps.
module tb_online_sd_to_tc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stage=4 instance for directed vectors
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_digit = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_data;

    // Stage=8 instance for random frames
    logic       r_rst = 1'b1;
    logic       r_in_valid = 1'b0;
    logic       r_in_ready;
    logic [1:0] r_in_digit = 2'b00;
    logic       r_out_valid;
    logic       r_out_ready = 1'b0;
    logic [8:0] r_out_data;

    online_sd_to_tc #(.Stage(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    online_sd_to_tc #(.Stage(8)) dut8 (
        .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_digit(r_in_digit),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present four digits back-to-back (digit 0 in bits [7:6]); returns #1 after the last accepting edge.
    task automatic send4(input logic [7:0] dig, input bit check_pre);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_digit = dig[7-2*k -: 2];
            @(negedge clk);
            if (check_pre && k == 3) chk("no_early_valid", int'(out_valid), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [4:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"}, int'(out_data), int'(exp));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] dig;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vt[8];

    // Random-phase scoreboard
    int exp_q[$];
    int acc;
    int dig_idx;
    int frames_sent;
    int frames_rcvd;
    int cur_val;
    logic [1:0] cur_enc;
    bit have_digit;
    bit timed_out;

    function automatic int enc_val(input logic [1:0] e);
        if (e == 2'b10) return 1;
        if (e == 2'b01) return -1;
        return 0;
    endfunction

    initial begin
        vt[0] = '{8'b10_00_01_00, 5'b00110, "p6"};
        vt[1] = '{8'b01_01_01_01, 5'b10001, "m15"};
        vt[2] = '{8'b10_10_10_10, 5'b01111, "p15"};
        vt[3] = '{8'b10_01_01_01, 5'b00001, "p1"};
        vt[4] = '{8'b11_00_11_00, 5'b00000, "zero"};
        vt[5] = '{8'b00_00_00_01, 5'b11111, "m1"};
        vt[6] = '{8'b01_10_00_00, 5'b11100, "m4"};
        vt[7] = '{8'b00_11_10_01, 5'b00001, "p1b"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        r_rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Table-driven frames, out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send4(vt[i].dig, 1'b1);
            expect_result(vt[i].name, vt[i].exp);
            @(negedge clk);
            chk({vt[i].name, "_drained"}, int'(out_valid), 0);
            @(posedge clk); #1;
        end

        // Backpressure: A=+6 pending, B=+12 streamed immediately
        out_ready = 1'b0;
        send4(8'b10_00_01_00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_digit = (k < 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("bp_early_ready", int'(in_ready), 1);
            chk("bp_hold_data", int'(out_data), 6);
            @(posedge clk); #1;
        end
        in_digit = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_stall_ready", int'(in_ready), 0);
            chk("bp_stall_valid", int'(out_valid), 1);
            chk("bp_stall_data", int'(out_data), 6);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_result("bp_b", 5'b01100);
        @(negedge clk);
        chk("bp_drained", int'(out_valid), 0);
        @(posedge clk); #1;

        // Reset mid-frame discards the partial frame
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_digit = 2'b01;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        send4(8'b10_00_00_00, 1'b1);
        expect_result("after_rst", 5'b01000);

        // Reset with a result pending
        out_ready = 1'b0;
        send4(8'b00_00_00_01, 1'b1);
        @(negedge clk);
        chk("pend_valid", int'(out_valid), 1);
        chk("pend_data", int'(out_data), 31);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("pendrst_valid", int'(out_valid), 0);
        chk("pendrst_data", int'(out_data), 0);
        @(posedge clk); #1;

        // Random frames on the Stage=8 instance
        acc = 0;
        dig_idx = 0;
        frames_sent = 0;
        frames_rcvd = 0;
        have_digit = 1'b0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 50000; cyc++) begin
            if (!have_digit && frames_sent < 1000) begin
                cur_enc = 2'($urandom_range(0, 3));
                have_digit = 1'b1;
            end
            r_in_valid = have_digit && ($urandom_range(0, 3) != 0);
            r_in_digit = r_in_valid ? cur_enc : 2'($urandom_range(0, 3));
            r_out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (r_out_valid && r_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_result", 1, 0);
                end else begin
                    chk("rnd_result", int'($signed(r_out_data)), exp_q.pop_front());
                    frames_rcvd++;
                end
            end
            if (r_in_valid && r_in_ready) begin
                cur_val = enc_val(cur_enc);
                acc += cur_val * (1 << (7 - dig_idx));
                dig_idx++;
                have_digit = 1'b0;
                if (dig_idx == 8) begin
                    exp_q.push_back(acc);
                    acc = 0;
                    dig_idx = 0;
                    frames_sent++;
                end
            end
            @(posedge clk); #1;
            if (frames_rcvd == 1000) begin
                timed_out = 1'b0;
                break;
            end
        end
        r_in_valid = 1'b0;
        r_out_ready = 1'b0;
        chk("rnd_timeout", int'(timed_out), 0);
        chk("rnd_frames_rcvd", frames_rcvd, 1000);
        chk("rnd_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("rnd_no_extra", int'(r_out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
